// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle control unit.
// Opcodes are 6 bits and are zero-extended when OPC_W is wider.
package ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  localparam logic [5:0] OP_AND  = 6'b100000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_JR   = 6'b001000;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_NOR  = 6'b100110;
  localparam logic [5:0] OP_NORI = 6'b001110;
  localparam logic [5:0] OP_NOT  = 6'b000100;
  localparam logic [5:0] OP_BLEU = 6'b010000;
  localparam logic [5:0] OP_ROLV = 6'b000000;
  localparam logic [5:0] OP_RORV = 6'b000010;

  localparam logic [1:0] ASB_REG   = 2'b00;
  localparam logic [1:0] ASB_FOUR  = 2'b01;
  localparam logic [1:0] ASB_IMM   = 2'b10;
  localparam logic [1:0] ASB_SHIMM = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;
  localparam logic [1:0] PCS_REG    = 2'b11;

endpackage

// File: rtl/opcode_decode.sv
// Combinational opcode classifier feeding the control FSM.
// is_imm marks nori, the only immediate-ALU instruction.
module opcode_decode
  import ctrl_pkg::*;
#(
  parameter int OPC_W = 6
) (
  input  logic [OPC_W-1:0] opc,
  output logic             is_rtype,
  output logic             is_imm,
  output logic             is_mem,
  output logic             is_load,
  output logic             is_branch,
  output logic             is_jump,
  output logic             is_link,
  output logic             legal
);

  logic op_and, op_lw, op_sw, op_jr, op_jal, op_nor, op_nori, op_not, op_bleu, op_rolv, op_rorv;

  assign op_and  = (opc == OPC_W'(OP_AND));
  assign op_lw   = (opc == OPC_W'(OP_LW));
  assign op_sw   = (opc == OPC_W'(OP_SW));
  assign op_jr   = (opc == OPC_W'(OP_JR));
  assign op_jal  = (opc == OPC_W'(OP_JAL));
  assign op_nor  = (opc == OPC_W'(OP_NOR));
  assign op_nori = (opc == OPC_W'(OP_NORI));
  assign op_not  = (opc == OPC_W'(OP_NOT));
  assign op_bleu = (opc == OPC_W'(OP_BLEU));
  assign op_rolv = (opc == OPC_W'(OP_ROLV));
  assign op_rorv = (opc == OPC_W'(OP_RORV));

  assign is_rtype  = op_and | op_nor | op_not | op_rolv | op_rorv;
  assign is_imm    = op_nori;
  assign is_mem    = op_lw | op_sw;
  assign is_load   = op_lw;
  assign is_branch = op_bleu;
  assign is_jump   = op_jr | op_jal;
  assign is_link   = op_jal;
  assign legal     = is_rtype | is_imm | is_mem | is_branch | is_jump;

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle control unit: sequences FETCH/DECODE/EXEC/MEM/WB and drives datapath controls.
// FETCH/MEM completion strobes and mem_err depend on mem_ready; all else is Moore.
//
// state  | meaning
// FETCH  | read instruction at PC, load IR and PC+4 on mem_ready; retry on timeout
// DECODE | classify opcode, precompute branch target
// EXEC   | ALU operation, address calc, or branch/jump completion
// MEM    | data access for lw/sw, held until mem_ready or timeout
// WB     | register-file write
module multicycle_control_fsm
  import ctrl_pkg::*;
#(
  parameter int OPC_W       = 6,
  parameter int ALU_W       = 5,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = $clog2(MEM_TIMEOUT + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      ins,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             ir_write,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       pc_src,
  output logic [ALU_W-1:0] alu_control,
  output logic [2:0]       state,
  output logic             mem_err,
  output logic             illegal
);

  state_t           cur_state, next_state;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic             waiting, timeout;
  logic             is_rtype, is_imm, is_mem, is_load, is_branch, is_jump, is_link, legal;
  logic             unused_ins;

  opcode_decode #(.OPC_W(OPC_W)) u_dec (
    .opc      (ins[31 -: OPC_W]),
    .is_rtype (is_rtype),
    .is_imm   (is_imm),
    .is_mem   (is_mem),
    .is_load  (is_load),
    .is_branch(is_branch),
    .is_jump  (is_jump),
    .is_link  (is_link),
    .legal    (legal)
  );

  assign alu_control = ins[31 -: ALU_W];
  assign state       = cur_state;
  assign timeout     = (wait_cnt == CNT_W'(MEM_TIMEOUT));
  assign unused_ins  = ^ins;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cur_state <= FETCH;
      wait_cnt  <= '0;
    end else begin
      cur_state <= next_state;
      wait_cnt  <= wait_cnt_nxt;
    end
  end

  // Counter only advances while stalled; any state change or timeout clears it.
  assign wait_cnt_nxt = waiting ? wait_cnt + CNT_W'(1) : '0;

  always_comb begin
    next_state    = cur_state;
    waiting       = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_write      = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = ASB_REG;
    pc_src        = PCS_ALU;
    mem_err       = 1'b0;
    illegal       = 1'b0;
    case (cur_state)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = ASB_FOUR;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          pc_src     = PCS_ALU;
          next_state = DECODE;
        end else if (timeout) begin
          mem_err = 1'b1;
        end else begin
          waiting = 1'b1;
        end
      end
      DECODE: begin
        alu_src_b = ASB_SHIMM;
        if (legal) begin
          next_state = EXEC;
        end else begin
          illegal    = 1'b1;
          next_state = FETCH;
        end
      end
      EXEC: begin
        next_state = FETCH;
        if (is_rtype) begin
          alu_src_a  = 1'b1;
          alu_src_b  = ASB_REG;
          next_state = WB;
        end else if (is_imm) begin
          alu_src_b  = ASB_IMM;
          next_state = WB;
        end else if (is_mem) begin
          alu_src_a  = 1'b1;
          alu_src_b  = ASB_IMM;
          next_state = MEM;
        end else if (is_branch) begin
          alu_src_a     = 1'b1;
          alu_src_b     = ASB_REG;
          pc_write_cond = 1'b1;
          pc_src        = PCS_ALUOUT;
        end else if (is_jump) begin
          pc_write = 1'b1;
          if (is_link) begin
            pc_src     = PCS_JUMP;
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
          end else begin
            pc_src = PCS_REG;
          end
        end
      end
      MEM: begin
        iord      = 1'b1;
        mem_read  = is_load;
        mem_write = ~is_load;
        if (mem_ready) begin
          next_state = is_load ? WB : FETCH;
        end else if (timeout) begin
          mem_err    = 1'b1;
          next_state = FETCH;
        end else begin
          waiting = 1'b1;
        end
      end
      WB: begin
        reg_write  = 1'b1;
        reg_dst    = is_rtype;
        mem_to_reg = is_load;
        next_state = FETCH;
      end
      default: next_state = FETCH;
    endcase
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Parametrised multicycle control unit that replaces the single-register lw/sw "second round" scheme with an explicit FETCH/DECODE/EXEC/MEM/WB state machine.
- Drives the datapath mux selects, the PC/IR/register-file write enables and the memory strobes.
- Waits on a memory ready handshake, with a configurable timeout.
- Sits between the instruction register output and the multicycle datapath.

Parameters:
OPC_W, 6, opcode width; the opcode is ins[31 -: OPC_W]. Minimum 6.
ALU_W, 5, ALU control width; alu_control = ins[31 -: ALU_W].
MEM_TIMEOUT, 15, maximum wait cycles for mem_ready in FETCH or MEM before an error. Range 1..255.
CNT_W, $clog2(MEM_TIMEOUT+1), width of the wait counter.

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
ins  in  32  instruction register output
mem_ready  in  1  memory access complete; sampled in FETCH and MEM
pc_write  out  1  unconditional PC write
pc_write_cond  out  1  PC write gated by the datapath compare (bleu)
ir_write  out  1  load IR from memory data
iord  out  1  0 selects PC as the memory address, 1 selects ALU out
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
mem_to_reg  out  1  register-file write data from memory or link
reg_write  out  1  register-file write enable
reg_dst  out  1  destination register is rd (R-type)
alu_src_a  out  1  0 selects PC, 1 selects register A
alu_src_b  out  2  00 reg B, 01 const 4, 10 sign-extended immediate, 11 shifted immediate
pc_src  out  2  00 ALU result, 01 ALU out register, 10 jump target, 11 register (jr)
alu_control  out  ALU_W  ALU operation select
state  out  3  current state, for debug
mem_err  out  1  one-cycle pulse on memory timeout
illegal  out  1  one-cycle pulse on an undecoded opcode

Behaviour:
- Reset (asynchronous): state = FETCH, wait counter = 0, all strobes and enables 0, selects 0. Outputs are Moore except the FETCH/MEM completion strobes.
- FETCH:
  - Outputs: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01.
  - When mem_ready=1: ir_write=1, pc_write=1, pc_src=00, go to DECODE.
  - Otherwise the counter increments.
  - counter == MEM_TIMEOUT with no mem_ready: mem_err pulse, counter cleared, stay in FETCH (retry).
- DECODE (1 cycle): alu_src_a=0, alu_src_b=11 (branch target precompute).
  - Known opcode: go to EXEC.
  - Unknown opcode: illegal pulse, go to FETCH.
- EXEC:
  - R-type (and, nor, not, rolv, rorv): alu_src_a=1, alu_src_b=00, go to WB.
  - nori: alu_src_b=10, go to WB.
  - lw/sw: alu_src_a=1, alu_src_b=10 (address), go to MEM.
  - bleu: alu_src_a=1, alu_src_b=00, pc_write_cond=1, pc_src=01, go to FETCH.
  - jr: pc_write=1, pc_src=11, go to FETCH.
  - jal: pc_write=1, pc_src=10, reg_write=1, mem_to_reg=1, go to FETCH.
- MEM: iord=1, with mem_read=1 for lw or mem_write=1 for sw, held until mem_ready.
  - lw: on mem_ready go to WB.
  - sw: on mem_ready go to FETCH.
  - Timeout: same counter rule as FETCH; mem_err pulse and abort to FETCH with no register write.
- WB (1 cycle): reg_write=1; reg_dst=1 for R-type; mem_to_reg=1 for lw. Go to FETCH.
- The counter clears on every state change.
- mem_ready arriving in the same cycle the counter reaches MEM_TIMEOUT counts as success; no mem_err.
- alu_control is combinational from ins in every state.
- Write strobes (pc_write, ir_write, reg_write, mem_write) are never asserted in two consecutive states for the same instruction.
- Reset asserted mid-MEM drops mem_write immediately (asynchronous).

Decomposition:
- Package ctrl_pkg holds:
  - state_t enum: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.
  - Opcode constants: OP_AND=100000, OP_LW=100011, OP_SW=101011, OP_JR=001000, OP_JAL=000011, OP_NOR=100110, OP_NORI=001110, OP_NOT=000100, OP_BLEU=010000, OP_ROLV=000000, OP_RORV=000010.
  - alu_src_b and pc_src encodings.
- One sub-module, opcode_decode: combinational; produces per-class flags (is_rtype, is_mem, is_load, is_branch, is_jump, is_link, legal).

Test Plan:
- Reset, then mem_ready=1 permanently, ins=100000 (and) → state sequence 0,1,2,4,0; reg_write=1 and reg_dst=1 only in WB; 4 cycles per instruction.
- lw with mem_ready held low for 3 cycles in MEM → MEM lasts 4 cycles with mem_read=1 and iord=1; then WB with mem_to_reg=1 and reg_write=1; no mem_err.
- sw with mem_ready never asserted, MEM_TIMEOUT=15 → mem_write high for 16 cycles; mem_err pulses once; next state FETCH; reg_write stays 0.
- jal → in EXEC: pc_write=1, pc_src=10, reg_write=1, mem_to_reg=1; next state FETCH; total 3 cycles.
- ins=111111 (illegal) → illegal pulses in DECODE; next state FETCH; no write strobes.
- Reset asserted asynchronously mid-MEM on a sw → mem_write falls before the next clock edge; state=0 after release.
